// File: rtl/iter_alu_if.sv
// Request/response bundle for iter_alu: the operation request (Start, opcode, operands)
// and the registered result and handshake (Busy, Done, Out, flags).
interface iter_alu_if #(
  parameter int WIDTH = 8
);
  logic             Start;
  logic [2:0]       OP;
  logic [1:0]       Function;
  logic [WIDTH-1:0] InputA;
  logic [WIDTH-1:0] InputB;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Out;
  logic [WIDTH-1:0] OutHi;
  logic             Zero;
  logic             Carry;
  logic             Err;

  // The requester (core or bench) drives the operation and sees the result.
  modport master (
    output Start, OP, Function, InputA, InputB,
    input  Busy, Done, Out, OutHi, Zero, Carry, Err
  );

  // The ALU receives the operation and drives the result.
  modport slave (
    input  Start, OP, Function, InputA, InputB,
    output Busy, Done, Out, OutHi, Zero, Carry, Err
  );
endinterface

// File: rtl/iter_alu.sv
// Multi-cycle ALU with a Start/Busy/Done handshake.
// Single-cycle ops finish one edge after Start. Shifts move one bit per cycle.
// MUL is a WIDTH-step shift-add multiplier producing a 2*WIDTH-bit product.
module iter_alu #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input logic        Clk,
  input logic        ResetN,
  iter_alu_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;

  localparam logic [SHW-1:0]   CNT_FULL   = SHW'(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_AS_B = WIDTH'(WIDTH);
  localparam logic [SHW-1:0]   CNT_ONE    = SHW'(1);

  state_t           state_reg;
  logic [WIDTH-1:0] w_reg;      // shift working value / multiplicand
  logic [WIDTH-1:0] b_reg;      // multiplier, becomes the product low half
  logic [WIDTH-1:0] hi_reg;     // product high half accumulator
  logic [SHW-1:0]   cnt_reg;    // remaining shift steps / multiply iterations
  logic [1:0]       kind_reg;   // latched Function: selects SLL/SRL/SRA
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] outhi_reg;
  logic             zero_reg;
  logic             carry_reg;
  logic             err_reg;

  logic             legal;
  logic             is_shift;
  logic             is_mul;
  logic             alu_carry;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   add_sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next;
  logic [WIDTH-1:0] mul_lo_next;

  // Decode the request and compute every single-cycle result from the live inputs.
  always_comb begin
    legal     = 1'b1;
    is_shift  = 1'b0;
    is_mul    = 1'b0;
    alu_res   = '0;
    alu_carry = 1'b0;
    add_sum   = {1'b0, bus.InputA} + {1'b0, bus.InputB};
    // Any amount of WIDTH or more saturates to WIDTH steps.
    shamt     = (bus.InputB >= WIDTH_AS_B) ? CNT_FULL : bus.InputB[SHW-1:0];
    case (bus.OP)
      3'd0: begin
        alu_res   = add_sum[WIDTH-1:0];
        alu_carry = add_sum[WIDTH];
      end
      3'd1: begin
        case (bus.Function)
          2'd0:    alu_res = bus.InputA & bus.InputB;
          2'd1:    alu_res = bus.InputA ^ bus.InputB;
          default: legal = 1'b0;
        endcase
      end
      3'd2: begin
        case (bus.Function)
          2'd0:    alu_res = bus.InputA | bus.InputB;
          2'd1: begin
            alu_res   = bus.InputA - bus.InputB;
            alu_carry = (bus.InputA >= bus.InputB);
          end
          default: legal = 1'b0;
        endcase
      end
      3'd3: begin
        if (bus.Function != 2'd3) is_shift = 1'b1;
        else                      legal    = 1'b0;
      end
      3'd4: begin
        if (bus.Function == 2'd0) is_mul = 1'b1;
        else                      legal  = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

  // One-bit step of the working register; SRA keeps replicating the original sign bit.
  always_comb begin
    case (kind_reg)
      2'd0:    shift_next = w_reg << 1;
      2'd1:    shift_next = w_reg >> 1;
      default: shift_next = $unsigned($signed(w_reg) >>> 1);
    endcase
  end

  // One shift-add step: conditionally add the multiplicand, then shift {carry, hi, lo} right.
  always_comb begin
    mul_sum     = {1'b0, hi_reg} + (b_reg[0] ? {1'b0, w_reg} : '0);
    mul_hi_next = mul_sum[WIDTH:1];
    mul_lo_next = {mul_sum[0], b_reg[WIDTH-1:1]};
  end

  // Control FSM with all datapath and result registers; results load on entry to DONE.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state_reg <= IDLE;
      w_reg     <= '0;
      b_reg     <= '0;
      hi_reg    <= '0;
      cnt_reg   <= '0;
      kind_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      out_reg   <= '0;
      outhi_reg <= '0;
      zero_reg  <= 1'b0;
      carry_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.Start) begin
            busy_reg <= 1'b1;
            kind_reg <= bus.Function;
            w_reg    <= bus.InputA;
            b_reg    <= bus.InputB;
            if (!legal) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
              out_reg   <= '0;
              outhi_reg <= '0;
              zero_reg  <= 1'b1;
              carry_reg <= 1'b0;
              err_reg   <= 1'b1;
            end else if (is_shift && shamt != '0) begin
              state_reg <= SHIFT;
              cnt_reg   <= shamt;
            end else if (is_shift) begin
              // Zero-length shift passes A through.
              state_reg <= DONE;
              done_reg  <= 1'b1;
              out_reg   <= bus.InputA;
              outhi_reg <= '0;
              zero_reg  <= (bus.InputA == '0);
              carry_reg <= 1'b0;
              err_reg   <= 1'b0;
            end else if (is_mul) begin
              state_reg <= MUL;
              hi_reg    <= '0;
              cnt_reg   <= CNT_FULL;
            end else begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
              out_reg   <= alu_res;
              outhi_reg <= '0;
              zero_reg  <= (alu_res == '0);
              carry_reg <= alu_carry;
              err_reg   <= 1'b0;
            end
          end
        end
        SHIFT: begin
          w_reg   <= shift_next;
          cnt_reg <= cnt_reg - CNT_ONE;
          if (cnt_reg == CNT_ONE) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
            out_reg   <= shift_next;
            outhi_reg <= '0;
            zero_reg  <= (shift_next == '0);
            carry_reg <= 1'b0;
            err_reg   <= 1'b0;
          end
        end
        MUL: begin
          hi_reg  <= mul_hi_next;
          b_reg   <= mul_lo_next;
          cnt_reg <= cnt_reg - CNT_ONE;
          if (cnt_reg == CNT_ONE) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
            out_reg   <= mul_lo_next;
            outhi_reg <= mul_hi_next;
            zero_reg  <= (mul_lo_next == '0);
            carry_reg <= 1'b0;
            err_reg   <= 1'b0;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.Busy  = busy_reg;
  assign bus.Done  = done_reg;
  assign bus.Out   = out_reg;
  assign bus.OutHi = outhi_reg;
  assign bus.Zero  = zero_reg;
  assign bus.Carry = carry_reg;
  assign bus.Err   = err_reg;

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu (WIDTH=8): directed operations push their hand-computed
// result into a queue, and a monitor compares it whenever Done pulses.
module tb_iter_alu;

  typedef struct {
    logic [7:0] out;
    logic [7:0] hi;
    logic       z;
    logic       c;
    logic       e;
    int         lat;
    int         acc;
    string      name;
  } exp_t;

  logic Clk;
  logic ResetN;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  iter_alu_if #(.WIDTH(8)) bus ();

  iter_alu #(.WIDTH(8)) dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .bus    (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge Clk);
      if (bus.Done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done at cycle %0d: got Done=1 expected no result", cyc);
        end else begin
          x = sb.pop_front();
          chk({x.name, ".out"},   32'(bus.Out),   32'(x.out));
          chk({x.name, ".hi"},    32'(bus.OutHi), 32'(x.hi));
          chk({x.name, ".zero"},  32'(bus.Zero),  32'(x.z));
          chk({x.name, ".carry"}, 32'(bus.Carry), 32'(x.c));
          chk({x.name, ".err"},   32'(bus.Err),   32'(x.e));
          chk({x.name, ".lat"},   32'(cyc - x.acc + 1), 32'(x.lat));
          $display("op %-10s out=%02h hi=%02h z=%0b c=%0b e=%0b lat=%0d", x.name,
                   bus.Out, bus.OutHi, bus.Zero, bus.Carry, bus.Err, cyc - x.acc + 1);
        end
      end
    end
  end

  task automatic expect_result(input string name, input logic [7:0] eo, input logic [7:0] eh,
                               input logic ez, input logic ec, input logic ee, input int lat);
    exp_t x;
    x.out = eo; x.hi = eh; x.z = ez; x.c = ec; x.e = ee; x.lat = lat;
    x.acc = cyc + 1;
    x.name = name;
    sb.push_back(x);
  endtask

  // Wait (bounded) until the scoreboard drains, then one more cycle so the ALU is back in IDLE.
  task automatic drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(negedge Clk);
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: got %0d pending results expected 0", name, sb.size());
      sb.delete();
    end
    @(negedge Clk);
  endtask

  // Issue one operation at a negedge; operands are scrambled right after the accept edge.
  task automatic run(input string name, input logic [2:0] op, input logic [1:0] fn,
                     input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] eo, input logic [7:0] eh,
                     input logic ez, input logic ec, input logic ee, input int lat);
    expect_result(name, eo, eh, ez, ec, ee, lat);
    bus.Start = 1'b1; bus.OP = op; bus.Function = fn; bus.InputA = a; bus.InputB = b;
    @(negedge Clk);
    bus.Start = 1'b0; bus.InputA = ~a; bus.InputB = ~b;
    drain(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    ResetN = 1'b0;
    bus.Start = 1'b0; bus.OP = 3'd0; bus.Function = 2'd0; bus.InputA = 8'h00; bus.InputB = 8'h00;
    repeat (3) @(negedge Clk);
    chk("reset.busy",  32'(bus.Busy),  32'd0);
    chk("reset.done",  32'(bus.Done),  32'd0);
    chk("reset.out",   32'(bus.Out),   32'd0);
    chk("reset.hi",    32'(bus.OutHi), 32'd0);
    chk("reset.zero",  32'(bus.Zero),  32'd0);
    chk("reset.carry", 32'(bus.Carry), 32'd0);
    chk("reset.err",   32'(bus.Err),   32'd0);
    ResetN = 1'b1;
    @(negedge Clk);

    //     name        op    fn    A      B      Out    OutHi  Z     C     E     lat
    run("add_1_1",   3'd0, 2'd0, 8'h01, 8'h01, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    run("add_ff_1",  3'd0, 2'd3, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1);
    run("sub_4_1",   3'd2, 2'd1, 8'h04, 8'h01, 8'h03, 8'h00, 1'b0, 1'b1, 1'b0, 1);
    run("sub_1_4",   3'd2, 2'd1, 8'h01, 8'h04, 8'hFD, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    run("sub_eq",    3'd2, 2'd1, 8'h37, 8'h37, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1);
    run("or",        3'd2, 2'd0, 8'h04, 8'h01, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    run("xor",       3'd1, 2'd1, 8'hF0, 8'hFF, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    run("and",       3'd1, 2'd0, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    run("sll_1",     3'd3, 2'd0, 8'h04, 8'h01, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 2);
    run("srl_7",     3'd3, 2'd1, 8'h80, 8'h07, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8);
    run("sra_3",     3'd3, 2'd2, 8'h80, 8'h03, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, 4);
    run("sra_pos",   3'd3, 2'd2, 8'h70, 8'h02, 8'h1C, 8'h00, 1'b0, 1'b0, 1'b0, 3);
    run("sll_0",     3'd3, 2'd0, 8'h5A, 8'h00, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    run("srl_200",   3'd3, 2'd1, 8'hAB, 8'hC8, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 9);
    run("sra_9",     3'd3, 2'd2, 8'h80, 8'h09, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 9);
    run("mul_d_b",   3'd4, 2'd0, 8'h0D, 8'h0B, 8'h8F, 8'h00, 1'b0, 1'b0, 1'b0, 9);
    run("mul_80_2",  3'd4, 2'd0, 8'h80, 8'h02, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 9);
    run("ill_op5",   3'd5, 2'd0, 8'h12, 8'h34, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1);
    run("add_clr",   3'd0, 2'd0, 8'h03, 8'h04, 8'h07, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    run("ill_sh3",   3'd3, 2'd3, 8'h12, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1);
    run("ill_mul1",  3'd4, 2'd1, 8'h12, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1);

    // MUL 0xFF*0xFF with an ignored second Start before edge 3; Busy high for edges 0-8.
    expect_result("mul_ff_ff", 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 9);
    bus.Start = 1'b1; bus.OP = 3'd4; bus.Function = 2'd0; bus.InputA = 8'hFF; bus.InputB = 8'hFF;
    for (int k = 0; k <= 8; k++) begin
      @(negedge Clk);
      bus.Start = 1'b0;
      if (k == 2) begin
        bus.Start = 1'b1; bus.OP = 3'd0; bus.InputA = 8'h02; bus.InputB = 8'h03;
      end
      chk($sformatf("mul_ff_ff.busy%0d", k), 32'(bus.Busy), 32'd1);
    end
    bus.Start = 1'b0;
    @(negedge Clk);
    chk("mul_ff_ff.busy9", 32'(bus.Busy), 32'd0);
    drain("mul_ff_ff");

    // Reset mid-MUL: accept at edge 0, ResetN low at edge 4, no Done afterwards.
    bus.Start = 1'b1; bus.OP = 3'd4; bus.Function = 2'd0; bus.InputA = 8'h0F; bus.InputB = 8'h0F;
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (3) @(negedge Clk);
    ResetN = 1'b0;
    @(negedge Clk);
    chk("rst_mul.busy",  32'(bus.Busy),  32'd0);
    chk("rst_mul.done",  32'(bus.Done),  32'd0);
    chk("rst_mul.out",   32'(bus.Out),   32'd0);
    chk("rst_mul.hi",    32'(bus.OutHi), 32'd0);
    chk("rst_mul.zero",  32'(bus.Zero),  32'd0);
    chk("rst_mul.carry", 32'(bus.Carry), 32'd0);
    chk("rst_mul.err",   32'(bus.Err),   32'd0);
    $display("op rst_mul    busy=%0b done=%0b out=%02h hi=%02h", bus.Busy, bus.Done, bus.Out, bus.OutHi);
    ResetN = 1'b1;
    repeat (12) @(negedge Clk);
    run("add_after", 3'd0, 2'd0, 8'h10, 8'h20, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1);

    repeat (3) @(negedge Clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
